// File: rtl/uart_alu_interface_if.sv
// Receiver/ALU/transmitter bus for the UART-ALU sequencing stage.
// The slave modport belongs to the sequencer; the master modport belongs to whatever drives it.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_rx_done_tick;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done_tick;
    logic [NB_DATA-1:0] o_alu_data_a;
    logic [NB_DATA-1:0] o_alu_data_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;

    modport slave (
        input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data, o_tx_start, o_busy
    );

    modport master (
        output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data, o_tx_start, o_busy
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, drives the ALU,
// then hands the result to the transmitter and waits for it to finish.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    uart_alu_interface_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_RESULT  = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic [NB_DATA-1:0] data_a_q,   data_a_d;
    logic [NB_DATA-1:0] data_b_q,   data_b_d;
    logic [NB_OP-1:0]   op_q,       op_d;
    logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;

    // State and datapath registers; reset discards any partial operation.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Next-state and register-load decode; receiver strobes are ignored while busy.
    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (bus.i_rx_done_tick) begin
                    data_a_d = bus.i_rx_data;
                    state_d  = ST_WAIT_B;
                end else begin
                    state_d  = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_done_tick) begin
                    data_b_d = bus.i_rx_data;
                    state_d  = ST_WAIT_OP;
                end else begin
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done_tick) begin
                    op_d    = bus.i_rx_data[NB_OP-1:0];
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_RESULT: begin
                // The ALU has had a full cycle since the opcode loaded.
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.i_tx_done_tick) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    assign bus.o_alu_data_a = data_a_q;
    assign bus.o_alu_data_b = data_b_q;
    assign bus.o_alu_op     = op_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_busy       = (state_q == ST_RESULT) || (state_q == ST_WAIT_TX);
endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed self-checking bench for uart_alu_interface with a small ADD/SUB ALU model.
module tb_uart_alu_interface;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    int   p0;
    logic       alu_force;
    logic [7:0] alu_rand;
    logic [7:0] alu_res;

    uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (alu_force) begin
            alu_res = alu_rand;
        end else begin
            case (bus.o_alu_op)
                6'h20:   alu_res = bus.o_alu_data_a + bus.o_alu_data_b;
                6'h22:   alu_res = bus.o_alu_data_a - bus.o_alu_data_b;
                default: alu_res = 8'h00;
            endcase
        end
    end
    assign bus.i_alu_result = alu_res;

    always @(posedge clk) if (bus.o_tx_start === 1'b1) pulses++;

    // All tasks are entered on a negedge and return on a negedge.
    task automatic pulse(input logic rx, input logic [7:0] d, input logic tx);
        bus.i_rx_done_tick = rx;
        bus.i_rx_data      = d;
        bus.i_tx_done_tick = tx;
        @(negedge clk);
        bus.i_rx_done_tick = 1'b0;
        bus.i_tx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        checks++; if (bus.o_alu_data_a !== 8'h00) begin failures++; $display("FAIL %s a got=%h exp=00", tag, bus.o_alu_data_a); end
        checks++; if (bus.o_alu_data_b !== 8'h00) begin failures++; $display("FAIL %s b got=%h exp=00", tag, bus.o_alu_data_b); end
        checks++; if (bus.o_alu_op !== 6'h00) begin failures++; $display("FAIL %s op got=%h exp=00", tag, bus.o_alu_op); end
        checks++; if (bus.o_tx_data !== 8'h00) begin failures++; $display("FAIL %s tx_data got=%h exp=00", tag, bus.o_tx_data); end
        checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL %s tx_start got=%b exp=0", tag, bus.o_tx_start); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%b exp=0", tag, bus.o_busy); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_rx_done_tick = 1'($urandom);
            bus.i_rx_data      = 8'($urandom);
            bus.i_tx_done_tick = 1'($urandom);
            alu_rand           = 8'($urandom);
            @(negedge clk);
        end
        check_zero("reset_hold");
        bus.i_rx_done_tick = 1'b0;
        bus.i_tx_done_tick = 1'b0;
        rst_n = 1'b1;
        idle(2);
        check_zero("reset_release");
        pulse(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL txdone_idle busy got=%b exp=0", bus.o_busy); end
        alu_force = 1'b0;
        pulse(1'b1, 8'h5C, 1'b0);
        checks++; if (bus.o_alu_data_a !== 8'h5C) begin failures++; $display("FAIL reset_first_a got=%h exp=5C", bus.o_alu_data_a); end
        do_reset();
    endtask

    task automatic test_single_op();
        p0 = pulses;
        pulse(1'b1, 8'h05, 1'b0);
        pulse(1'b1, 8'h03, 1'b0);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_pre got=%b exp=0", bus.o_busy); end
        pulse(1'b1, 8'h20, 1'b0);
        checks++; if (bus.o_alu_op !== 6'h20) begin failures++; $display("FAIL single_op got=%h exp=20", bus.o_alu_op); end
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_result got=%b exp=1", bus.o_busy); end
        checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b exp=0", bus.o_tx_start); end
        @(negedge clk);
        checks++; if (bus.o_tx_data !== 8'h08) begin failures++; $display("FAIL single_tx_data got=%h exp=08", bus.o_tx_data); end
        checks++; if (bus.o_tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.o_tx_start); end
        @(negedge clk);
        checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL single_start_fall got=%b exp=0", bus.o_tx_start); end
        idle(4);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_wait got=%b exp=1", bus.o_busy); end
        pulse(1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", bus.o_busy); end
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses - p0); end
    endtask

    task automatic test_trunc_and_drop();
        p0 = pulses;
        pulse(1'b1, 8'hFF, 1'b0);
        pulse(1'b1, 8'h01, 1'b0);
        pulse(1'b1, 8'hE2, 1'b0);
        checks++; if (bus.o_alu_op !== 6'h22) begin failures++; $display("FAIL trunc_op got=%h exp=22", bus.o_alu_op); end
        idle(2);
        checks++; if (bus.o_tx_data !== 8'hFE) begin failures++; $display("FAIL trunc_tx_data got=%h exp=FE", bus.o_tx_data); end
        pulse(1'b1, 8'h7A, 1'b0);
        pulse(1'b1, 8'h11, 1'b0);
        pulse(1'b1, 8'h33, 1'b1);
        checks++; if (bus.o_alu_data_a !== 8'hFF) begin failures++; $display("FAIL drop_a got=%h exp=FF", bus.o_alu_data_a); end
        checks++; if (bus.o_alu_data_b !== 8'h01) begin failures++; $display("FAIL drop_b got=%h exp=01", bus.o_alu_data_b); end
        checks++; if (bus.o_alu_op !== 6'h22) begin failures++; $display("FAIL drop_op got=%h exp=22", bus.o_alu_op); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", bus.o_busy); end
        idle(2);
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", pulses - p0); end
        pulse(1'b1, 8'h09, 1'b0);
        checks++; if (bus.o_alu_data_a !== 8'h09) begin failures++; $display("FAIL drop_next_a got=%h exp=09", bus.o_alu_data_a); end
        checks++; if (bus.o_alu_data_b !== 8'h01) begin failures++; $display("FAIL drop_next_b got=%h exp=01", bus.o_alu_data_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(1'b1, 8'h10, 1'b0);
        pulse(1'b1, 8'h20, 1'b0);
        checks++; if (bus.o_alu_data_b !== 8'h20) begin failures++; $display("FAIL mid_b_loaded got=%h exp=20", bus.o_alu_data_b); end
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b1, 8'h44, 1'b0);
        checks++; if (bus.o_alu_data_a !== 8'h44) begin failures++; $display("FAIL mid_a got=%h exp=44", bus.o_alu_data_a); end
        checks++; if (bus.o_alu_op !== 6'h00) begin failures++; $display("FAIL mid_op got=%h exp=00", bus.o_alu_op); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.o_busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        p0 = pulses;
        pulse(1'b1, 8'h0C, 1'b0);
        pulse(1'b1, 8'h04, 1'b0);
        pulse(1'b1, 8'h20, 1'b0);
        @(negedge clk);
        checks++; if (bus.o_tx_data !== 8'h10) begin failures++; $display("FAIL b2b_first got=%h exp=10", bus.o_tx_data); end
        idle(2);
        pulse(1'b0, 8'h00, 1'b1);
        pulse(1'b1, 8'h30, 1'b0);
        checks++; if (bus.o_alu_data_a !== 8'h30) begin failures++; $display("FAIL b2b_a2 got=%h exp=30", bus.o_alu_data_a); end
        pulse(1'b1, 8'h10, 1'b0);
        pulse(1'b1, 8'h22, 1'b0);
        @(negedge clk);
        checks++; if (bus.o_tx_data !== 8'h20) begin failures++; $display("FAIL b2b_second got=%h exp=20", bus.o_tx_data); end
        checks++; if (bus.o_tx_start !== 1'b1) begin failures++; $display("FAIL b2b_start2 got=%b exp=1", bus.o_tx_start); end
        idle(2);
        pulse(1'b0, 8'h00, 1'b1);
        idle(2);
        checks++; if (pulses - p0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses - p0); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", bus.o_busy); end
    endtask

    initial begin
        alu_force          = 1'b0;
        alu_rand           = 8'h00;
        rst_n              = 1'b0;
        bus.i_rx_done_tick = 1'b0;
        bus.i_rx_data      = 8'h00;
        bus.i_tx_done_tick = 1'b0;
        test_reset();
        test_single_op();
        test_trunc_and_drop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Sequencing stage between the UART receiver and the ALU/transmitter in the TP2 UART datapath. It consumes the receiver's byte stream (`o_data` qualified by `o_rx_done_tick`), collects operand A, operand B and opcode in that order, and drives them to the combinational ALU. It then captures the ALU result, launches it on the UART transmitter, and waits for transmit completion before accepting the next operation.

## Interface
- `NB_DATA`, default 8: width of the received byte, the operands and the result.
- `NB_OP`, default 6: opcode width; the opcode is the low `NB_OP` bits of the third received byte.

- `i_clock`, input, 1: single clock for all logic.
- `i_reset`, input, 1: reset is asynchronous and active-low.
- `i_rx_done_tick`, input, 1: one-cycle strobe from the receiver; `i_rx_data` is valid while it is high.
- `i_rx_data`, input, `NB_DATA`: received byte.
- `i_alu_result`, input, `NB_DATA`: combinational ALU output.
- `i_tx_done_tick`, input, 1: one-cycle strobe from the transmitter at the end of its stop bit.
- `o_alu_data_a`, output, `NB_DATA`: registered operand A.
- `o_alu_data_b`, output, `NB_DATA`: registered operand B.
- `o_alu_op`, output, `NB_OP`: registered opcode.
- `o_tx_data`, output, `NB_DATA`: registered result presented to the transmitter.
- `o_tx_start`, output, 1: one-cycle transmit request.
- `o_busy`, output, 1: high in RESULT and WAIT_TX. Decoded directly from the state register.

## Operation
- The FSM has five states, binary encoded, 3 bits: WAIT_A, WAIT_B, WAIT_OP, RESULT, WAIT_TX.
- WAIT_A: on `i_rx_done_tick`, load `o_alu_data_a` with `i_rx_data` and go to WAIT_B.
- WAIT_B: on `i_rx_done_tick`, load `o_alu_data_b` and go to WAIT_OP.
- WAIT_OP: on `i_rx_done_tick`, load `o_alu_op` with `i_rx_data[NB_OP-1:0]` and go to RESULT. Upper bits are discarded.
- RESULT: unconditionally do the following in one cycle, then go to WAIT_TX:
  - load `o_tx_data` with `i_alu_result`;
  - assert `o_tx_start` for exactly one cycle.
- WAIT_TX: on `i_tx_done_tick`, go to WAIT_A. All `i_rx_done_tick` strobes in RESULT or WAIT_TX are dropped; no register changes.
- Simultaneous `i_rx_done_tick` and `i_tx_done_tick` in WAIT_TX: go to WAIT_A and drop the byte.
- `i_tx_done_tick` outside WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten. The ALU output therefore stays stable from RESULT through WAIT_TX.
- Reset, including mid-operation: state returns to WAIT_A. All outputs go to 0, with `o_tx_start`=0 and `o_busy`=0. A partially collected operation is discarded. There is no further reset behaviour.

## Timing
- All register updates occur on the rising edge of `i_clock`, except the asynchronous reset.
- Byte load latency: a strobe sampled at edge k makes the new register value visible after edge k.
- Opcode strobe at edge k:
  - edge k: `o_alu_op` loads and the state becomes RESULT.
  - edge k+1: `o_tx_data` loads and `o_tx_start` rises; the state becomes WAIT_TX.
  - edge k+2: `o_tx_start` falls.
- The ALU has a full cycle (k to k+1) to settle before capture.
- `o_busy` rises after edge k and falls after the edge that samples `i_tx_done_tick`.
- Back-to-back operation: a strobe arriving one cycle after the return to WAIT_A is accepted as operand A.
- No minimum spacing is required between receiver strobes in the collect states; each strobe advances exactly one state.

## Test plan
- Reset: hold `i_reset`=0 for 3 cycles with random inputs -> all outputs 0 and the state is WAIT_A. Release -> outputs unchanged until the first strobe.
- Single operation: strobe 0x05, 0x03, 0x20, with an ALU model ADD=6'b100000 -> `o_alu_op`=6'h20. One cycle later `o_tx_data`=0x08 and `o_tx_start` is a one-cycle pulse. `o_busy` stays 1 until `i_tx_done_tick`.
- Opcode truncation: strobe 0xFF, 0x01, 0xE2 (low bits 6'b100010 = SUB) -> `o_alu_op`=6'h22 and `o_tx_data`=0xFE.
- Drop while busy:
  - Stimulus: during WAIT_TX, strobe 0x7A and 0x11, then `i_tx_done_tick` in the same cycle as another strobe 0x33.
  - Required: A/B/op are unchanged, no second `o_tx_start`, and the state returns to WAIT_A. The next strobe 0x09 loads `o_alu_data_a`=0x09.
- Reset mid-operation: strobe A=0x10 and B=0x20, then pulse `i_reset` low asynchronously between edges -> immediate clear. A subsequent strobe 0x44 loads operand A, not the opcode.
- Back-to-back: two full operations, with the second A strobe on the first cycle after `i_tx_done_tick` -> two correct results and exactly two `o_tx_start` pulses.
